// File: rtl/phase_seq_pkg.sv
// Shared constants and types for the phase sequencer and the phase-driven datapath.
// The clamp helper keeps a programmed last phase inside the legal phase range.
package phase_seq_pkg;

  localparam int W_PHASE  = 3;
  localparam int N_PHASES = 6;
  localparam int W_DWELL  = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE
  } seq_state_t;

  function automatic logic [W_PHASE-1:0] clamp_last(input logic [W_PHASE-1:0] last);
    if (last > W_PHASE'(N_PHASES - 1)) begin
      return W_PHASE'(N_PHASES - 1);
    end
    return last;
  endfunction

endpackage

// File: rtl/phase_seq_ctrl_if.sv
// Control/status bundle between host logic (master) and the phase sequencer (slave).
interface phase_seq_ctrl_if;
  import phase_seq_pkg::*;

  logic               start;
  logic               stop;
  logic               pause;
  logic               loop_mode;
  logic [W_PHASE-1:0] cfg_last;
  logic [W_DWELL-1:0] cfg_dwell;
  logic [W_PHASE-1:0] phase;
  logic               phase_valid;
  logic               step;
  logic               wrap;
  logic               done;
  logic               busy;

  modport master (
    output start, stop, pause, loop_mode, cfg_last, cfg_dwell,
    input  phase, phase_valid, step, wrap, done, busy
  );

  modport slave (
    input  start, stop, pause, loop_mode, cfg_last, cfg_dwell,
    output phase, phase_valid, step, wrap, done, busy
  );

endinterface

// File: rtl/phase_seq_ctrl_dwell_counter.sv
// Loadable down counter that saturates at zero; zero flag is derived from the registered count.
module dwell_counter
  import phase_seq_pkg::*;
#(
  parameter int W = W_DWELL
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/phase_seq_ctrl.sv
// Phase sequencer: steps phase 0..last with a programmable dwell, one-shot or looping.
// Start/stop are pulses, pause is a level; every output is registered (1-cycle latency).
module phase_seq_ctrl
  import phase_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  phase_seq_ctrl_if.slave  ctl
);

  seq_state_t         state, nxt_state;
  logic [W_PHASE-1:0] phase_q, nxt_phase;
  logic [W_PHASE-1:0] last_r;
  logic               loop_r;
  logic [W_DWELL-1:0] dwell_r;
  logic               step_q, nxt_step;
  logic               wrap_q, nxt_wrap;
  logic               done_q, nxt_done;
  logic               busy_q, nxt_busy;
  logic               take_cfg;
  logic               cnt_load;
  logic               cnt_en;
  logic               cnt_zero;
  logic [W_DWELL-1:0] cnt_load_val;

  dwell_counter #(.W(W_DWELL)) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .en    (cnt_en),
    .value (cnt_load_val),
    .zero  (cnt_zero)
  );

  // The first dwell comes straight from the config port; later ones from the latched copy.
  assign cnt_load_val = (state == S_IDLE) ? ctl.cfg_dwell : dwell_r;

  always_comb begin
    nxt_state = state;
    nxt_phase = phase_q;
    nxt_step  = 1'b0;
    nxt_wrap  = 1'b0;
    nxt_done  = 1'b0;
    take_cfg  = 1'b0;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (ctl.start && !ctl.stop) begin
          nxt_state = S_RUN;
          nxt_phase = '0;
          take_cfg  = 1'b1;
          cnt_load  = 1'b1;
        end
      end
      S_RUN: begin
        if (ctl.stop) begin
          nxt_state = S_IDLE;
          nxt_phase = '0;
          nxt_done  = 1'b1;
        end else if (ctl.pause) begin
          nxt_state = S_PAUSE;
        end else if (!cnt_zero) begin
          cnt_en = 1'b1;
        end else if (phase_q < last_r) begin
          nxt_phase = phase_q + W_PHASE'(1);
          nxt_step  = 1'b1;
          cnt_load  = 1'b1;
        end else if (loop_r) begin
          nxt_phase = '0;
          nxt_step  = 1'b1;
          nxt_wrap  = 1'b1;
          cnt_load  = 1'b1;
        end else begin
          nxt_state = S_IDLE;
          nxt_phase = '0;
          nxt_done  = 1'b1;
        end
      end
      S_PAUSE: begin
        if (ctl.stop) begin
          nxt_state = S_IDLE;
          nxt_phase = '0;
          nxt_done  = 1'b1;
        end else if (!ctl.pause) begin
          nxt_state = S_RUN;
        end
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_phase = '0;
      end
    endcase
    nxt_busy = (nxt_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      phase_q <= '0;
      last_r  <= '0;
      loop_r  <= 1'b0;
      dwell_r <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= nxt_state;
      phase_q <= nxt_phase;
      step_q  <= nxt_step;
      wrap_q  <= nxt_wrap;
      done_q  <= nxt_done;
      busy_q  <= nxt_busy;
      if (take_cfg) begin
        last_r  <= clamp_last(ctl.cfg_last);
        loop_r  <= ctl.loop_mode;
        dwell_r <= ctl.cfg_dwell;
      end
    end
  end

  assign ctl.phase       = phase_q;
  assign ctl.phase_valid = busy_q;
  assign ctl.step        = step_q;
  assign ctl.wrap        = wrap_q;
  assign ctl.done        = done_q;
  assign ctl.busy        = busy_q;

endmodule

// File: tb/tb_phase_seq_ctrl.sv
// Directed bench for phase_seq_ctrl: one task per scenario, hand-computed expected outputs.
module tb_phase_seq_ctrl;
  import phase_seq_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  phase_seq_ctrl_if ifc ();

  phase_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .ctl (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector: {phase[2:0], phase_valid, step, wrap, done, busy}
  function automatic logic [7:0] obs();
    return {ifc.phase, ifc.phase_valid, ifc.step, ifc.wrap, ifc.done, ifc.busy};
  endfunction

  function automatic logic [7:0] ev(input int ph, input logic vld, input logic stp,
                                    input logic wrp, input logic dn, input logic bsy);
    logic [2:0] p;
    p = ph[2:0];
    return {p, vld, stp, wrp, dn, bsy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int last, input int dwell, input logic lp);
    ifc.cfg_last  = last[2:0];
    ifc.cfg_dwell = dwell[7:0];
    ifc.loop_mode = lp;
    ifc.start     = 1'b1;
    tick();
    ifc.start     = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rst       = 1'b0;
    ifc.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      e = ev(0, 0, 0, 0, 0, 0);
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL reset k=%0d got=%b exp=%b", k, obs(), e);
      end
    end
    ifc.start = 1'b0;
    rst       = 1'b1;
    tick();
    e = ev(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL reset_release got=%b exp=%b", obs(), e);
    end
  endtask

  task automatic test_one_shot();
    logic [7:0] e;
    int steps;
    steps = 0;
    launch(5, 1, 1'b0);
    for (int k = 0; k < 12; k++) begin
      e = ev(k / 2, 1, (k > 0) && (k % 2 == 0), 0, 0, 1);
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL oneshot k=%0d got=%b exp=%b", k, obs(), e);
      end
      if (ifc.step === 1'b1) steps++;
      tick();
    end
    e = ev(0, 0, 0, 0, 1, 0);
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL oneshot_done got=%b exp=%b", obs(), e);
    end
    checks++;
    if (steps !== 5) begin
      failures++;
      $display("FAIL oneshot_steps got=%0d exp=5", steps);
    end
    tick();
    e = ev(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL oneshot_after got=%b exp=%b", obs(), e);
    end
  endtask

  task automatic test_loop();
    logic [7:0] e;
    launch(2, 0, 1'b1);
    for (int k = 0; k < 9; k++) begin
      e = ev(k % 3, 1, k > 0, (k > 0) && (k % 3 == 0), 0, 1);
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL loop3 k=%0d got=%b exp=%b", k, obs(), e);
      end
      tick();
    end
    ifc.stop = 1'b1;
    tick();
    ifc.stop = 1'b0;
    e = ev(0, 0, 0, 0, 1, 0);
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL loop3_stop got=%b exp=%b", obs(), e);
    end
    launch(7, 0, 1'b1);
    for (int k = 0; k < 13; k++) begin
      e = ev(k % 6, 1, k > 0, (k > 0) && (k % 6 == 0), 0, 1);
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL loop_clamp k=%0d got=%b exp=%b", k, obs(), e);
      end
      tick();
    end
    ifc.stop = 1'b1;
    tick();
    ifc.stop = 1'b0;
    tick();
  endtask

  task automatic test_pause();
    logic [7:0] e;
    launch(3, 3, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    e = ev(1, 1, 1, 0, 0, 1);
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL pause_enter_phase1 got=%b exp=%b", obs(), e);
    end
    ifc.pause = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      e = ev(1, 1, 0, 0, 0, 1);
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL pause_hold k=%0d got=%b exp=%b", k, obs(), e);
      end
    end
    ifc.pause = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      e = ev(1, 1, 0, 0, 0, 1);
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL pause_resume k=%0d got=%b exp=%b", k, obs(), e);
      end
    end
    tick();
    e = ev(2, 1, 1, 0, 0, 1);
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL pause_next_phase got=%b exp=%b", obs(), e);
    end
    ifc.stop = 1'b1;
    tick();
    ifc.stop = 1'b0;
    tick();
  endtask

  task automatic test_stop();
    logic [7:0] e;
    launch(5, 0, 1'b0);
    tick();
    tick();
    tick();
    e = ev(3, 1, 1, 0, 0, 1);
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL stop_at_phase3 got=%b exp=%b", obs(), e);
    end
    ifc.stop = 1'b1;
    tick();
    ifc.stop = 1'b0;
    e = ev(0, 0, 0, 0, 1, 0);
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL stop_run got=%b exp=%b", obs(), e);
    end
    tick();
    e = ev(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL stop_done_single got=%b exp=%b", obs(), e);
    end
    launch(5, 0, 1'b0);
    ifc.pause = 1'b1;
    tick();
    tick();
    e = ev(0, 1, 0, 0, 0, 1);
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL stop_paused_hold got=%b exp=%b", obs(), e);
    end
    ifc.stop = 1'b1;
    tick();
    ifc.stop  = 1'b0;
    ifc.pause = 1'b0;
    e = ev(0, 0, 0, 0, 1, 0);
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL stop_pause got=%b exp=%b", obs(), e);
    end
    tick();
    ifc.start = 1'b1;
    ifc.stop  = 1'b1;
    tick();
    ifc.start = 1'b0;
    ifc.stop  = 1'b0;
    e = ev(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL start_stop_idle got=%b exp=%b", obs(), e);
    end
    tick();
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL start_stop_idle_after got=%b exp=%b", obs(), e);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    logic [7:0] exp_seq [5];
    exp_seq[0] = ev(0, 1, 0, 0, 0, 1);
    exp_seq[1] = ev(0, 1, 0, 0, 0, 1);
    exp_seq[2] = ev(1, 1, 1, 0, 0, 1);
    exp_seq[3] = ev(1, 1, 0, 0, 0, 1);
    exp_seq[4] = ev(2, 1, 1, 0, 0, 1);
    launch(3, 1, 1'b0);
    // New config and a held start must not disturb the running sequence.
    ifc.cfg_last  = 3'd1;
    ifc.cfg_dwell = 8'd0;
    ifc.loop_mode = 1'b1;
    ifc.start     = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) ifc.start = 1'b0;
      checks++;
      if (obs() !== exp_seq[k]) begin
        failures++;
        $display("FAIL busy_start k=%0d got=%b exp=%b", k, obs(), exp_seq[k]);
      end
      if (k < 4) tick();
    end
    rst = 1'b0;
    tick();
    e = ev(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL midrun_reset got=%b exp=%b", obs(), e);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL midrun_reset_release got=%b exp=%b", obs(), e);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b0;
    ifc.start     = 1'b0;
    ifc.stop      = 1'b0;
    ifc.pause     = 1'b0;
    ifc.loop_mode = 1'b0;
    ifc.cfg_last  = '0;
    ifc.cfg_dwell = '0;
    test_reset();
    test_one_shot();
    test_loop();
    test_pause();
    test_stop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
